// File: rtl/pipelined_functional_unit_if.sv
// Issue-side and CDB-side signal bundle of the pipelined functional unit.
// The slave modport is the functional unit; the master is the reservation station / CDB arbiter.
interface pipelined_functional_unit_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 3,
    parameter int CNT_W = 2
);
    logic             issue_valid;
    logic             issue_ready;
    logic [15:0]      issue_instr;
    logic [TAG_W-1:0] issue_tag;
    logic [WIDTH-1:0] R1;
    logic [WIDTH-1:0] R2;
    logic             cdb_valid;
    logic             cdb_grant;
    logic [WIDTH-1:0] cdb_result;
    logic [TAG_W-1:0] cdb_tag;
    logic [15:0]      cdb_instr;
    logic             cdb_err;
    logic             div_busy;
    logic [CNT_W-1:0] inflight;

    modport master (
        output issue_valid, issue_instr, issue_tag, R1, R2, cdb_grant,
        input  issue_ready, cdb_valid, cdb_result, cdb_tag, cdb_instr, cdb_err, div_busy, inflight
    );

    modport slave (
        input  issue_valid, issue_instr, issue_tag, R1, R2, cdb_grant,
        output issue_ready, cdb_valid, cdb_result, cdb_tag, cdb_instr, cdb_err, div_busy, inflight
    );
endinterface

// File: rtl/pipelined_functional_unit.sv
// Tomasulo execution unit: ADD/SUB/MUL/DIV with fixed per-class latency, a completion-slot
// line that guarantees one write per cycle into the output FIFO, and a CDB valid/grant drain.
module pipelined_functional_unit #(
    parameter int WIDTH     = 16,
    parameter int TAG_W     = 3,
    parameter int ADD_LAT   = 1,
    parameter int MUL_LAT   = 2,
    parameter int DIV_LAT   = 4,
    parameter int OUT_DEPTH = 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        flush,
    pipelined_functional_unit_if.slave  bus
);
    localparam int MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int MAX_LAT = (MAX_AM > DIV_LAT) ? MAX_AM : DIV_LAT;
    localparam int CNT_W   = $clog2(OUT_DEPTH + 1);
    localparam int PTR_W   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAG_W-1:0] tag;
        logic [15:0]      instr;
        logic             err;
        logic             is_div;
    } entry_t;

    localparam entry_t ENTRY_NONE = '0;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? {PTR_W{1'b0}} : p + 1'b1;
    endfunction

    entry_t             slot_p_r [MAX_LAT];
    entry_t             slot_p_s [MAX_LAT];
    logic [MAX_LAT-1:0] slot_v_r;
    logic [MAX_LAT-1:0] slot_v_s;
    entry_t             fifo_r [OUT_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   inflight_r;
    logic               div_busy_r;
    entry_t             new_s;
    int                 lat_s;
    logic               is_div_s;
    logic               slot_free_s;
    logic               credit_ok_s;
    logic               ready_s;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;
    logic               head_valid_s;

    // Execute the presented op up front; the result then rides the slot line for its latency
    always_comb begin
        new_s       = ENTRY_NONE;
        new_s.tag   = bus.issue_tag;
        new_s.instr = bus.issue_instr;
        lat_s       = ADD_LAT;
        is_div_s    = 1'b0;
        case (bus.issue_instr[3:0])
            4'b0000: new_s.result = bus.R2 + bus.R1;
            4'b0001: new_s.result = bus.R2 - bus.R1;
            4'b0100: begin
                new_s.result = bus.R2 * bus.R1;
                lat_s        = MUL_LAT;
            end
            4'b0101: begin
                lat_s        = DIV_LAT;
                is_div_s     = 1'b1;
                new_s.is_div = 1'b1;
                if (bus.R1 == {WIDTH{1'b0}}) begin
                    new_s.result = {WIDTH{1'b1}};
                    new_s.err    = 1'b1;
                end else begin
                    new_s.result = bus.R2 / bus.R1;
                end
            end
            default: new_s.err = 1'b1;
        endcase
    end

    // Slot bit L set now means that slot completes L edges after the coming one: clash check
    always_comb begin
        slot_free_s = 1'b1;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (i == lat_s) begin
                slot_free_s = ~slot_v_r[i];
            end else begin
                slot_free_s = slot_free_s;
            end
        end
        credit_ok_s = (int'(inflight_r) + int'(count_r) - int'(pop_s)) < OUT_DEPTH;
        ready_s     = ~flush & slot_free_s & (~is_div_s | ~div_busy_r) & credit_ok_s;
    end

    assign head_valid_s = (count_r != {CNT_W{1'b0}});
    assign pop_s        = head_valid_s & bus.cdb_grant;
    assign accept_s     = bus.issue_valid & ready_s;
    assign push_s       = slot_v_r[0];

    // Next slot line: shift toward completion, then drop the accepted op into slot LAT-1
    always_comb begin
        slot_v_s = slot_v_r >> 1;
        for (int i = 0; i < MAX_LAT - 1; i++) begin
            slot_p_s[i] = slot_p_r[i+1];
        end
        slot_p_s[MAX_LAT-1] = ENTRY_NONE;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (accept_s && (i == lat_s - 1)) begin
                slot_v_s[i] = 1'b1;
                slot_p_s[i] = new_s;
            end else begin
                slot_v_s[i] = slot_v_s[i];
                slot_p_s[i] = slot_p_s[i];
            end
        end
    end

    // Slot line register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_v_r <= {MAX_LAT{1'b0}};
            for (int i = 0; i < MAX_LAT; i++) slot_p_r[i] <= ENTRY_NONE;
        end else if (flush) begin
            slot_v_r <= {MAX_LAT{1'b0}};
            for (int i = 0; i < MAX_LAT; i++) slot_p_r[i] <= ENTRY_NONE;
        end else begin
            slot_v_r <= slot_v_s;
            for (int i = 0; i < MAX_LAT; i++) slot_p_r[i] <= slot_p_s[i];
        end
    end

    // Divider occupancy and in-flight count; a DIV is busy until its result lands in the FIFO
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_busy_r <= 1'b0;
            inflight_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            div_busy_r <= 1'b0;
            inflight_r <= {CNT_W{1'b0}};
        end else begin
            if (accept_s && is_div_s) begin
                div_busy_r <= 1'b1;
            end else if (push_s && slot_p_r[0].is_div) begin
                div_busy_r <= 1'b0;
            end else begin
                div_busy_r <= div_busy_r;
            end
            inflight_r <= inflight_r + CNT_W'(accept_s) - CNT_W'(push_s);
        end
    end

    // Output FIFO in completion order; the credit rule keeps a push from ever finding it full
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < OUT_DEPTH; i++) fifo_r[i] <= ENTRY_NONE;
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= slot_p_r[0];
                wr_ptr_r         <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    assign bus.issue_ready = ready_s;
    assign bus.cdb_valid   = head_valid_s;
    assign bus.cdb_result  = head_valid_s ? fifo_r[rd_ptr_r].result : {WIDTH{1'b0}};
    assign bus.cdb_tag     = head_valid_s ? fifo_r[rd_ptr_r].tag    : {TAG_W{1'b0}};
    assign bus.cdb_instr   = head_valid_s ? fifo_r[rd_ptr_r].instr  : 16'h000F;
    assign bus.cdb_err     = head_valid_s ? fifo_r[rd_ptr_r].err    : 1'b0;
    assign bus.div_busy    = div_busy_r;
    assign bus.inflight    = inflight_r;
endmodule
